// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: pairs issued PCs with in-order imem responses.
// Optional same-cycle response forwarding when empty is enabled by defining IQ_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH      = 4,
  parameter int PEND_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [31:0]                req_pc,
  input  logic                       imem_resp,
  input  logic [31:0]                imem_rdata,
  input  logic                       flush,
  input  logic                       deq_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       stall_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // A one-deep pending FIFO still uses a two-entry array so index slicing stays legal.
  localparam int PI = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int DW = $clog2(PEND_DEPTH) + 1;
  localparam int SW = CW + PI + 1;

  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [31:0]   pend_pc    [2**PI];
  logic [PI:0]   pend_wr, pend_rd, pending_cnt;
  logic [DW-1:0] drop_cnt;

  logic          empty, full, pend_full, pend_empty;
  logic          resp_pop, keep, bypass, deq, fifo_push, fifo_pop;
  logic [31:0]   resp_pc;
  logic [SW-1:0] credit_sum;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (count == CW'(DEPTH));
  assign pending_cnt = pend_wr - pend_rd;
  assign pend_full   = (pending_cnt == (PI+1)'(PEND_DEPTH));
  assign pend_empty  = (pending_cnt == '0);

  assign resp_pop = imem_resp && !pend_empty;
  assign resp_pc  = pend_pc[pend_rd[PI-1:0]];
  assign keep     = resp_pop && (drop_cnt == '0) && !flush;

`ifdef IQ_BYPASS_EN
  assign bypass = keep && empty;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = !empty || bypass;
    out_pc    = '0;
    out_instr = '0;
    if (bypass) begin
      out_pc    = resp_pc;
      out_instr = imem_rdata;
    end else if (!empty) begin
      out_pc    = fifo_pc[rd_ptr[AW-1:0]];
      out_instr = fifo_instr[rd_ptr[AW-1:0]];
    end
  end

  // A forwarded response taken by decode this cycle never occupies a slot.
  assign deq       = out_valid && deq_ready && !flush;
  assign fifo_pop  = deq && !empty;
  assign fifo_push = keep && !(bypass && deq_ready);

  assign credit_sum = SW'(count) + SW'(pending_cnt);
  assign stall_out  = (credit_sum >= SW'(DEPTH)) || pend_full;

  always_ff @(posedge clk) begin
    if (req_valid) pend_pc[pend_wr[PI-1:0]] <= req_pc;
    if (fifo_push) begin
      fifo_pc[wr_ptr[AW-1:0]]    <= resp_pc;
      fifo_instr[wr_ptr[AW-1:0]] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_wr  <= '0;
      pend_rd  <= '0;
      drop_cnt <= '0;
    end else begin
      if (req_valid) pend_wr <= pend_wr + 1'b1;
      if (resp_pop)  pend_rd <= pend_rd + 1'b1;
      if (flush) begin
        // Everything still outstanding before the redirect is stale; this cycle's response retires one.
        rd_ptr   <= wr_ptr;
        drop_cnt <= DW'(pending_cnt - (PI+1)'(resp_pop));
      end else begin
        if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
        if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (resp_pop && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_pend_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(req_valid && pend_full));
  a_resp_unmatched: assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp && pend_empty));
  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && full && !fifo_pop && !flush));

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: expected (pc, instr) pairs are queued by the driver and
// checked by an independent monitor whenever decode takes the head entry.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        deq_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic        stall_out;
  logic [2:0]  count;

  logic [63:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

`ifdef IQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  instr_queue #(.DEPTH(4), .PEND_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .flush(flush),
    .deq_ready(deq_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .stall_out(stall_out), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cycle(input logic rv, input logic [31:0] pc, input logic rs,
                       input logic [31:0] rd, input logic fl);
    req_valid  = rv;
    req_pc     = pc;
    imem_resp  = rs;
    imem_rdata = rd;
    flush      = fl;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_pc     = '0;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic req(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rd);
    cycle(1'b0, 32'h0, 1'b1, rd, 1'b0);
  endtask

  task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted head entry must match the oldest expected pair
  always @(negedge clk) begin
    if (rst && out_valid && deq_ready && !flush) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got pc %h instr %h, nothing expected", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          n_fail++;
          $display("FAIL out_pair: got pc %h instr %h expected pc %h instr %h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    // reset / basic
    idle(2);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_count", {29'b0, count}, 32'h0);
    check("rst_stall", {31'b0, stall_out}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    rst = 1'b1;
    deq_ready = 1'b1;
    req(32'h6000_0000);
    expect_pair(32'h6000_0000, 32'h0000_0013);
    imem_resp = 1'b1;
    imem_rdata = 32'h0000_0013;
    #2;
    check("basic_bypass_valid", {31'b0, out_valid}, {31'b0, BYP});
    @(posedge clk);
    #1;
    imem_resp = 1'b0;
    imem_rdata = '0;
    check("basic_latency_valid", {31'b0, out_valid}, {31'b0, !BYP});
    idle(1);
    check("basic_count_zero", {29'b0, count}, 32'h0);

    // fill / stall
    deq_ready = 1'b0;
    req(32'h6000_0000); resp(32'h0000_0113); expect_pair(32'h6000_0000, 32'h0000_0113);
    req(32'h6000_0004); resp(32'h0020_0193); expect_pair(32'h6000_0004, 32'h0020_0193);
    req(32'h6000_0008); resp(32'h0030_0213); expect_pair(32'h6000_0008, 32'h0030_0213);
    check("fill3_stall", {31'b0, stall_out}, 32'h0);
    req(32'h6000_000C);
    check("fill3_pend1_stall", {31'b0, stall_out}, 32'h1);
    resp(32'h0040_0293); expect_pair(32'h6000_000C, 32'h0040_0293);
    check("full_count", {29'b0, count}, 32'h4);
    check("full_stall", {31'b0, stall_out}, 32'h1);
    check("full_head_pc", out_pc, 32'h6000_0000);
    deq_ready = 1'b1;
    idle(1);
    deq_ready = 1'b0;
    check("deq_stall_clear", {31'b0, stall_out}, 32'h0);
    check("deq_count", {29'b0, count}, 32'h3);
    check("deq_head_pc", out_pc, 32'h6000_0004);

    // simultaneous push/pop at full
    req(32'h6000_0010);
    check("pend_stall", {31'b0, stall_out}, 32'h1);
    req(32'h6000_0014);
    resp(32'h0050_0313); expect_pair(32'h6000_0010, 32'h0050_0313);
    check("full2_count", {29'b0, count}, 32'h4);
    deq_ready = 1'b1;
    resp(32'h0060_0393); expect_pair(32'h6000_0014, 32'h0060_0393);
    check("pushpop_count", {29'b0, count}, 32'h4);
    check("pushpop_head_pc", out_pc, 32'h6000_0008);
    idle(4);
    check("drain_count", {29'b0, count}, 32'h0);
    check("drain_stall", {31'b0, stall_out}, 32'h0);

    // flush with in-flight responses; the redirect request survives
    req(32'h6000_0020);
    req(32'h6000_0024);
    cycle(1'b1, 32'h6000_0100, 1'b0, 32'h0, 1'b1);
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    resp(32'hDEAD_BEEF);
    check("drop1_count", {29'b0, count}, 32'h0);
    resp(32'hDEAD_BEEF);
    check("drop2_count", {29'b0, count}, 32'h0);
    expect_pair(32'h6000_0100, 32'h0010_0093);
    resp(32'h0010_0093);
    idle(2);

    // flush together with a response
    req(32'h6000_0200);
    cycle(1'b0, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b1);
    check("flushresp_out_valid", {31'b0, out_valid}, 32'h0);
    check("flushresp_count", {29'b0, count}, 32'h0);
    req(32'h6000_0204);
    expect_pair(32'h6000_0204, 32'h0000_0033);
    resp(32'h0000_0033);
    idle(2);

    // reset mid-operation
    deq_ready = 1'b0;
    req(32'h6000_0300); resp(32'h0000_1111);
    req(32'h6000_0304); resp(32'h0000_2222);
    req(32'h6000_0308); resp(32'h0000_3333);
    req(32'h6000_030C);
    check("prerst_count", {29'b0, count}, 32'h3);
    rst = 1'b0;
    exp_q.delete();
    idle(1);
    rst = 1'b1;
    check("midrst_count", {29'b0, count}, 32'h0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_stall", {31'b0, stall_out}, 32'h0);
    deq_ready = 1'b1;
    req(32'h6000_0400);
    expect_pair(32'h6000_0400, 32'h0000_0073);
    resp(32'h0000_0073);
    idle(3);

    check("final_exp_q_empty", exp_q.size(), 32'h0);
    check("final_count", {29'b0, count}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
